core_mem_arbiter: RTL and testbench

Shares one external memory port between the core's instruction-fetch (imem) and load/store (dmem) request/grant interfaces. Sits between the core's two memory ports and the single-ported memory or bus bridge. Zero-latency combinational routing, a registered ownership lock to keep requests stable until granted, and a bounded-starvation priority scheme: dmem normally wins, but imem is guaranteed service after STARVE_MAX consecutive contested dmem grants.

---
 rtl/core_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//
// Shares one external memory port between the core's instruction-fetch
// (imem) and load/store (dmem) request/grant interfaces. Routing is purely
// combinational; a registered owner lock keeps the shared-port payload
// stable from the first mem_req cycle until mem_gnt. dmem normally wins a
// contested cycle, but after STARVE_MAX consecutive contested dmem grants
// imem is forced through.
//
// Ports:
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   imem_* / dmem_* (in)     req, addr, wen, strb, wdata from each requester
//   imem_* / dmem_* (out)    gnt, err, rdata back to each requester
//   mem_* (out)              req, addr, wen, strb, wdata to the shared port
//   mem_* (in)               gnt, err, rdata from the shared port
//   starve_cnt               contested-dmem-grant count (observability)

module core_mem_arbiter #(
  parameter int MEM_ADDR_W = 64,
  parameter int MEM_DATA_W = 64,
  parameter int MEM_STRB_W = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,

  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,

  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,

  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata,

  output logic [3:0]            starve_cnt
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  owner_e     sel;
  logic       sel_req;
  logic [3:0] starve_q, starve_d;

  // Requester selection. A held lock wins outright; otherwise dmem has
  // priority unless imem has been starved long enough. Nothing is selected
  // while reset is asserted so no grant can leak out during reset.
  always_comb begin
    sel = OWN_NONE;
    if (!g_resetn) begin
      sel = OWN_NONE;
    end else if (owner_q != OWN_NONE) begin
      sel = owner_q;
    end else if (imem_req && dmem_req) begin
      sel = (starve_q < StarveLimit) ? OWN_DMEM : OWN_IMEM;
    end else if (imem_req) begin
      sel = OWN_IMEM;
    end else if (dmem_req) begin
      sel = OWN_DMEM;
    end
  end

  // Shared-port payload mux; all zero when nobody is selected.
  always_comb begin
    sel_req   = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_strb  = '0;
    mem_wdata = '0;
    case (sel)
      OWN_IMEM: begin
        sel_req   = imem_req;
        mem_addr  = imem_addr;
        mem_wen   = imem_wen;
        mem_strb  = imem_strb;
        mem_wdata = imem_wdata;
      end
      OWN_DMEM: begin
        sel_req   = dmem_req;
        mem_addr  = dmem_addr;
        mem_wen   = dmem_wen;
        mem_strb  = dmem_strb;
        mem_wdata = dmem_wdata;
      end
      default: begin
        sel_req = 1'b0;
      end
    endcase
  end

  assign mem_req = sel_req;

  // Grants are also qualified by the selected request so that an owner
  // which drops its request before completion never sees a grant.
  assign imem_gnt   = mem_gnt & sel_req & (sel == OWN_IMEM);
  assign dmem_gnt   = mem_gnt & sel_req & (sel == OWN_DMEM);
  assign imem_err   = mem_err & imem_gnt;
  assign dmem_err   = mem_err & dmem_gnt;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign starve_cnt = starve_q;

  // Lock is only taken when a request waits; a same-cycle grant leaves the
  // port free. A held lock is released on grant or on request withdrawal.
  always_comb begin
    owner_d = owner_q;
    if (owner_q == OWN_NONE) begin
      if (sel != OWN_NONE && sel_req && !mem_gnt) begin
        owner_d = sel;
      end
    end else if (mem_gnt || !sel_req) begin
      owner_d = OWN_NONE;
    end
  end

  // Count contested dmem grants, saturating at 15; any imem grant clears.
  always_comb begin
    starve_d = starve_q;
    if (dmem_gnt && imem_req) begin
      if (starve_q != 4'hF) begin
        starve_d = starve_q + 4'd1;
      end
    end else if (imem_gnt) begin
      starve_d = 4'd0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Testbench for core_mem_arbiter: directed scenarios followed by a
// randomized protocol-following traffic run checked against a reference
// model of the arbitration rules.

module tb_core_mem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, dmem_req;
  logic [63:0] imem_addr, dmem_addr;
  logic        imem_wen, dmem_wen;
  logic [7:0]  imem_strb, dmem_strb;
  logic [63:0] imem_wdata, dmem_wdata;
  logic        imem_gnt, dmem_gnt, imem_err, dmem_err;
  logic [63:0] imem_rdata, dmem_rdata;
  logic        mem_req, mem_wen, mem_gnt, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;
  logic [3:0]  starve_cnt;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  core_mem_arbiter #(
    .MEM_ADDR_W(64), .MEM_DATA_W(64), .MEM_STRB_W(8), .STARVE_MAX(4)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata),
    .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .starve_cnt(starve_cnt)
  );

  // Advance to the next low phase, where inputs are changed.
  task automatic nextCycle();
    @(posedge g_clk);
    @(negedge g_clk);
  endtask

  task automatic clearInputs();
    imem_req = 0; imem_addr = 0; imem_wen = 0; imem_strb = 0; imem_wdata = 0;
    dmem_req = 0; dmem_addr = 0; dmem_wen = 0; dmem_strb = 0; dmem_wdata = 0;
    mem_gnt = 0; mem_err = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    @(negedge g_clk);
    clearInputs();
    g_resetn = 0;
    imem_req = 1; imem_addr = 64'h1000;
    dmem_req = 1; dmem_addr = 64'h2000;
    mem_gnt = 1;
    #1;
    checks++;
    if (starve_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_starve: got %0d want 0", starve_cnt);
    end
    checks++;
    if ({imem_gnt, dmem_gnt} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_nognt: got %b want 00", {imem_gnt, dmem_gnt});
    end
    nextCycle();
    g_resetn = 1; mem_gnt = 0; dmem_req = 0; dmem_addr = 0;
    #1;
    checks++;
    if (mem_addr !== 64'h1000 || mem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_release: got req=%b addr=%h want 1 1000", mem_req, mem_addr);
    end
    mem_gnt = 1;
    nextCycle();
    clearInputs();
  endtask

  task automatic test_lock();
    dmem_req = 1; dmem_addr = 64'hAAAA; dmem_wdata = 64'h55; dmem_wen = 1; dmem_strb = 8'h0F;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin imem_req = 1; imem_addr = 64'hBBBB; end
      if (c == 3) mem_gnt = 1;
      #1;
      checks++;
      if (mem_addr !== 64'hAAAA || mem_wdata !== 64'h55 || mem_wen !== 1'b1 || mem_strb !== 8'h0F) begin
        errors++; $display("[TB] FAIL lock_payload c%0d: got addr=%h want aaaa", c, mem_addr);
      end
      checks++;
      if ({imem_gnt, dmem_gnt} !== {1'b0, (c == 3)}) begin
        errors++; $display("[TB] FAIL lock_gnt c%0d: got %b want %b", c, {imem_gnt, dmem_gnt}, {1'b0, (c == 3)});
      end
      nextCycle();
    end
    dmem_req = 0; mem_gnt = 0;
    #1;
    checks++;
    if (mem_addr !== 64'hBBBB || mem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL lock_next_imem: got %h want bbbb", mem_addr);
    end
    checks++;
    if (starve_cnt !== 4'd1) begin
      errors++; $display("[TB] FAIL lock_starve: got %0d want 1", starve_cnt);
    end
    mem_gnt = 1;
    nextCycle();
    clearInputs();
  endtask

  task automatic test_starvation();
    imem_req = 1; imem_addr = 64'h11; dmem_req = 1; dmem_addr = 64'h22; mem_gnt = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (c == 4) begin
        if (imem_gnt !== 1'b1 || dmem_gnt !== 1'b0 || starve_cnt !== 4'd4) begin
          errors++; $display("[TB] FAIL starve_c4: got ig=%b dg=%b cnt=%0d want 1 0 4", imem_gnt, dmem_gnt, starve_cnt);
        end
      end else begin
        if (dmem_gnt !== 1'b1 || imem_gnt !== 1'b0 || starve_cnt !== ((c == 5) ? 4'd0 : 4'(c))) begin
          errors++; $display("[TB] FAIL starve_c%0d: got ig=%b dg=%b cnt=%0d", c, imem_gnt, dmem_gnt, starve_cnt);
        end
      end
      nextCycle();
    end
    imem_req = 1; dmem_req = 0;
    nextCycle();
    clearInputs();
  endtask

  task automatic test_error();
    imem_req = 1; imem_addr = 64'h300;
    nextCycle();
    mem_gnt = 1; mem_err = 1; mem_rdata = 64'hDEAD;
    #1;
    checks++;
    if ({imem_gnt, imem_err, dmem_err} !== 3'b110 || imem_rdata !== 64'hDEAD || dmem_rdata !== 64'hDEAD) begin
      errors++; $display("[TB] FAIL err_route: got ig=%b ie=%b de=%b rd=%h want 1 1 0 dead",
                         imem_gnt, imem_err, dmem_err, imem_rdata);
    end
    nextCycle();
    clearInputs();
  endtask

  task automatic test_abort_and_reset_midlock();
    dmem_req = 1; dmem_addr = 64'h400;
    nextCycle();
    imem_req = 1; imem_addr = 64'h500;
    nextCycle();
    dmem_req = 0; mem_gnt = 1;
    #1;
    checks++;
    if ({mem_req, imem_gnt, dmem_gnt} !== 3'b000) begin
      errors++; $display("[TB] FAIL abort_nognt: got %b want 000", {mem_req, imem_gnt, dmem_gnt});
    end
    nextCycle();
    mem_gnt = 0;
    #1;
    checks++;
    if (mem_addr !== 64'h500 || mem_req !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_reselect: got %h want 500", mem_addr);
    end
    nextCycle();
    dmem_req = 1; dmem_addr = 64'h600; mem_gnt = 1;
    g_resetn = 0;
    #1;
    checks++;
    if ({imem_gnt, dmem_gnt} !== 2'b00) begin
      errors++; $display("[TB] FAIL midlock_nognt: got %b want 00", {imem_gnt, dmem_gnt});
    end
    nextCycle();
    g_resetn = 1; mem_gnt = 0;
    #1;
    checks++;
    if (mem_addr !== 64'h600 || starve_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL midlock_dmem_wins: got %h cnt=%0d want 600 0", mem_addr, starve_cnt);
    end
    mem_gnt = 1;
    nextCycle();
    dmem_req = 0;
    nextCycle();
    clearInputs();
  endtask

  // Randomized traffic. Each requester holds a pending transaction until
  // granted (occasionally abandoning it); the model applies the arbitration
  // rules directly: who is waiting, who has priority, how long imem waited.
  task automatic test_random();
    int          lockWho;
    int          starveModel;
    bit          iPend, dPend;
    int          who, reqOfWho;
    bit          expIg, expDg;
    logic [63:0] expAddr;

    @(negedge g_clk);
    clearInputs();
    g_resetn = 0;
    nextCycle();
    g_resetn = 1;
    lockWho = 0; starveModel = 0; iPend = 0; dPend = 0;

    for (int c = 0; c < 600; c++) begin
      if (!iPend && $urandom_range(2) == 0) begin
        iPend = 1; imem_addr = {$urandom, $urandom}; imem_wdata = {$urandom, $urandom};
        imem_wen = 1'($urandom); imem_strb = 8'($urandom);
      end else if (iPend && $urandom_range(24) == 0) iPend = 0;
      if (!dPend && $urandom_range(2) == 0) begin
        dPend = 1; dmem_addr = {$urandom, $urandom}; dmem_wdata = {$urandom, $urandom};
        dmem_wen = 1'($urandom); dmem_strb = 8'($urandom);
      end else if (dPend && $urandom_range(24) == 0) dPend = 0;
      imem_req = iPend; dmem_req = dPend;
      mem_gnt = 1'($urandom); mem_err = 1'($urandom); mem_rdata = {$urandom, $urandom};

      if (lockWho != 0) who = lockWho;
      else if (iPend && dPend) who = (starveModel >= 4) ? 1 : 2;
      else if (iPend) who = 1;
      else if (dPend) who = 2;
      else who = 0;
      reqOfWho = (who == 1) ? int'(iPend) : (who == 2) ? int'(dPend) : 0;
      expAddr = (who == 1) ? imem_addr : (who == 2) ? dmem_addr : 64'd0;
      expIg = mem_gnt && reqOfWho == 1 && who == 1;
      expDg = mem_gnt && reqOfWho == 1 && who == 2;

      #1;
      checks++;
      if (mem_req !== 1'(reqOfWho) || mem_addr !== expAddr) begin
        errors++; $display("[TB] FAIL rand_route c%0d: got req=%b addr=%h want %0d %h", c, mem_req, mem_addr, reqOfWho, expAddr);
      end
      checks++;
      if ({imem_gnt, dmem_gnt} !== {expIg, expDg} || {imem_err, dmem_err} !== {expIg & mem_err, expDg & mem_err}) begin
        errors++; $display("[TB] FAIL rand_gnt c%0d: got g=%b e=%b want g=%b", c, {imem_gnt, dmem_gnt}, {imem_err, dmem_err}, {expIg, expDg});
      end
      checks++;
      if (starve_cnt !== 4'(starveModel) || imem_rdata !== mem_rdata || dmem_rdata !== mem_rdata) begin
        errors++; $display("[TB] FAIL rand_state c%0d: got cnt=%0d want %0d", c, starve_cnt, starveModel);
      end

      if (lockWho == 0) begin
        if (reqOfWho == 1 && !mem_gnt) lockWho = who;
      end else if (mem_gnt || reqOfWho == 0) lockWho = 0;
      if (expDg && iPend) starveModel = (starveModel < 15) ? starveModel + 1 : 15;
      else if (expIg) starveModel = 0;
      if (expIg) iPend = 0;
      if (expDg) dPend = 0;
      nextCycle();
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    g_resetn = 0;
    test_reset();
    test_lock();
    test_starvation();
    test_error();
    test_abort_and_reset_midlock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
